// File: rtl/bist_scan_controller.sv
// Logic-BIST sequencer: loads LFSR patterns through the scan chain, pulses
// capture, unloads the last response into the MISR and checks the signature.
//
// state   | meaning
// IDLE    | waiting for bist_start
// INIT    | seed LFSR, clear MISR, clear pattern count and result
// SHIFT   | load next pattern (and compact previous response when one exists)
// CAPTURE | functional capture of the loaded pattern
// UNLOAD  | shift out the final response into the MISR
// COMPARE | sample misr_sig against GOLDEN
// DONE    | result valid until bist_start drops
module bist_scan_controller #(
    parameter int              SCAN_LEN   = 8,
    parameter int              N_PATTERNS = 1000,
    parameter int              SIG_W      = 16,
    parameter logic [SIG_W-1:0] GOLDEN    = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bist_start,
    input  logic [SIG_W-1:0] misr_sig,
    output logic             gen_init,
    output logic             scan_en,
    output logic             lfsr_en,
    output logic             misr_en,
    output logic             capture,
    output logic [15:0]      pattern_cnt,
    output logic             bist_end,
    output logic             pass_nfail
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_COMPARE,
        S_DONE
    } state_t;

    localparam logic [7:0]  SHIFT_LAST = 8'(SCAN_LEN - 1);
    localparam logic [15:0] PAT_TOTAL  = 16'(N_PATTERNS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_shift_cnt;
    logic [7:0]  w_shift_cnt_nxt;
    logic [15:0] r_pattern_cnt;
    logic [15:0] w_pattern_cnt_nxt;
    logic [15:0] w_pattern_inc;
    logic        r_pass;
    logic        w_pass_nxt;

    logic r_gen_init, r_scan_en, r_lfsr_en, r_misr_en, r_capture, r_bist_end;
    logic w_gen_init_nxt, w_scan_en_nxt, w_lfsr_en_nxt, w_misr_en_nxt;
    logic w_capture_nxt, w_bist_end_nxt;

    assign w_pattern_inc = r_pattern_cnt + 16'd1;

    always_comb begin
        w_state_nxt       = r_state;
        w_shift_cnt_nxt   = r_shift_cnt;
        w_pattern_cnt_nxt = r_pattern_cnt;
        w_pass_nxt        = r_pass;

        case (r_state)
            S_IDLE: begin
                if (bist_start) begin
                    w_state_nxt       = S_INIT;
                    w_pattern_cnt_nxt = 16'd0;
                    w_pass_nxt        = 1'b0;
                end
            end
            S_INIT: begin
                w_state_nxt     = S_SHIFT;
                w_shift_cnt_nxt = 8'd0;
            end
            S_SHIFT: begin
                if (r_shift_cnt == SHIFT_LAST) begin
                    w_state_nxt     = S_CAPTURE;
                    w_shift_cnt_nxt = 8'd0;
                end else begin
                    w_shift_cnt_nxt = r_shift_cnt + 8'd1;
                end
            end
            S_CAPTURE: begin
                w_pattern_cnt_nxt = w_pattern_inc;
                w_shift_cnt_nxt   = 8'd0;
                w_state_nxt       = (w_pattern_inc == PAT_TOTAL) ? S_UNLOAD : S_SHIFT;
            end
            S_UNLOAD: begin
                if (r_shift_cnt == SHIFT_LAST) begin
                    w_state_nxt     = S_COMPARE;
                    w_shift_cnt_nxt = 8'd0;
                end else begin
                    w_shift_cnt_nxt = r_shift_cnt + 8'd1;
                end
            end
            S_COMPARE: begin
                w_pass_nxt  = (misr_sig == GOLDEN);
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (!bist_start) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up
    // with the state they belong to. The first load has no response to compact.
    always_comb begin
        w_gen_init_nxt = (w_state_nxt == S_INIT);
        w_scan_en_nxt  = (w_state_nxt == S_SHIFT) || (w_state_nxt == S_UNLOAD);
        w_lfsr_en_nxt  = (w_state_nxt == S_SHIFT);
        w_misr_en_nxt  = ((w_state_nxt == S_SHIFT) && (w_pattern_cnt_nxt != 16'd0))
                         || (w_state_nxt == S_UNLOAD);
        w_capture_nxt  = (w_state_nxt == S_CAPTURE);
        w_bist_end_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_shift_cnt   <= 8'd0;
            r_pattern_cnt <= 16'd0;
            r_pass        <= 1'b0;
            r_gen_init    <= 1'b0;
            r_scan_en     <= 1'b0;
            r_lfsr_en     <= 1'b0;
            r_misr_en     <= 1'b0;
            r_capture     <= 1'b0;
            r_bist_end    <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_shift_cnt   <= w_shift_cnt_nxt;
            r_pattern_cnt <= w_pattern_cnt_nxt;
            r_pass        <= w_pass_nxt;
            r_gen_init    <= w_gen_init_nxt;
            r_scan_en     <= w_scan_en_nxt;
            r_lfsr_en     <= w_lfsr_en_nxt;
            r_misr_en     <= w_misr_en_nxt;
            r_capture     <= w_capture_nxt;
            r_bist_end    <= w_bist_end_nxt;
        end
    end

    assign gen_init    = r_gen_init;
    assign scan_en     = r_scan_en;
    assign lfsr_en     = r_lfsr_en;
    assign misr_en     = r_misr_en;
    assign capture     = r_capture;
    assign pattern_cnt = r_pattern_cnt;
    assign bist_end    = r_bist_end;
    assign pass_nfail  = r_pass;

endmodule

// File: doc/bist_scan_controller.md
BIST_SCAN_CONTROLLER -- requirements
Module: bist_scan_controller

Interface
REQ-001 SHALL have parameter SCAN_LEN, default 8: scan chain length in flops, range 2..255.
REQ-002 SHALL have parameter N_PATTERNS, default 1000: number of pseudo-random patterns applied, range 1..65535.
REQ-003 SHALL have parameter SIG_W, default 16: MISR signature width.
REQ-004 SHALL have parameter GOLDEN, default 16'h0000: expected fault-free signature, SIG_W bits.
REQ-005 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port bist_start, input, 1 bit: level request to run BIST.
REQ-008 SHALL have port misr_sig, input, SIG_W bits: current MISR signature from the datapath.
REQ-009 SHALL have port gen_init, output, 1 bit: seeds the LFSR and clears the MISR.
REQ-010 SHALL have port scan_en, output, 1 bit: chain in shift mode.
REQ-011 SHALL have port lfsr_en, output, 1 bit: advances the LFSR.
REQ-012 SHALL have port misr_en, output, 1 bit: compacts scan-out into the MISR.
REQ-013 SHALL have port capture, output, 1 bit: functional capture pulse.
REQ-014 SHALL have port pattern_cnt, output, 16 bits: patterns captured so far.
REQ-015 SHALL have port bist_end, output, 1 bit: run complete.
REQ-016 SHALL have port pass_nfail, output, 1 bit: 1 means the signature matched GOLDEN.

Function
REQ-017 SHALL implement the states IDLE, INIT, SHIFT, CAPTURE, UNLOAD, COMPARE and DONE, with registered Moore outputs.
REQ-018 In IDLE, bist_start=1 at a rising edge SHALL move the FSM to INIT; otherwise it SHALL stay in IDLE.
REQ-019 INIT SHALL last 1 cycle: gen_init=1, pattern_cnt cleared to 0, pass_nfail cleared to 0, next state SHIFT.
REQ-020 SHIFT SHALL last exactly SCAN_LEN cycles, counted by an 8-bit shift counter from 0 to SCAN_LEN-1.
REQ-021 During SHIFT: scan_en=1 and lfsr_en=1; misr_en=1 only when pattern_cnt>0, because the first load carries no response.
REQ-022 CAPTURE SHALL last 1 cycle: scan_en=0, capture=1, and pattern_cnt incremented at exit.
REQ-023 After CAPTURE, the FSM SHALL go to UNLOAD if the incremented pattern_cnt equals N_PATTERNS, else to SHIFT.
REQ-024 UNLOAD SHALL last SCAN_LEN cycles: scan_en=1, misr_en=1, lfsr_en=0; this unloads the final response.
REQ-025 COMPARE SHALL last 1 cycle: misr_sig is sampled, pass_nfail <= (misr_sig == GOLDEN), next state DONE.
REQ-026 DONE SHALL hold bist_end=1 and pass_nfail stable while bist_start=1; bist_start=0 SHALL return the FSM to IDLE, clearing bist_end.
REQ-027 bist_start changes in any state other than IDLE and DONE SHALL be ignored, and the run SHALL continue.
REQ-028 bist_start already high on entry to IDLE SHALL start a new run on the next edge.
REQ-029 gen_init, scan_en, lfsr_en, misr_en and capture SHALL be 0 in all states not listed above for them.
REQ-030 No two of capture, gen_init and scan_en SHALL ever be high in the same cycle.
REQ-031 pass_nfail SHALL keep its last result in IDLE until the next INIT.
REQ-032 pattern_cnt SHALL keep its final value through DONE and IDLE.
REQ-033 pattern_cnt SHALL never wrap; its maximum reachable value is N_PATTERNS.
REQ-034 Total run length from the bist_start sampling edge to bist_end=1 SHALL be 1 + N_PATTERNS*(SCAN_LEN+1) + SCAN_LEN + 1 cycles.

Reset
REQ-035 reset=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, all counters 0, every output 0.
REQ-036 reset asserted mid-run SHALL abort the run without producing a pass result.
REQ-037 After reset=1, the first rising edge SHALL sample bist_start normally.

Verification
REQ-038 Bench SHALL cover a nominal run with SCAN_LEN=4, N_PATTERNS=3, GOLDEN=misr_sig: bist_start=1 -> bist_end rises 21 cycles after the sampling edge, pass_nfail=1, pattern_cnt=3.
REQ-039 Bench SHALL cover a signature mismatch with the same parameters and misr_sig != GOLDEN in COMPARE -> bist_end=1, pass_nfail=0.
REQ-040 Bench SHALL cover the enable profile: gen_init=1 for 1 cycle; scan_en=1 for 4 cycles with misr_en=0 in pattern 0; misr_en=1 in patterns 1-2 and in UNLOAD; capture pulses exactly 3 times.
REQ-041 Bench SHALL cover bist_start toggled low/high mid-run -> timing and result identical to the nominal run.
REQ-042 Bench SHALL cover reset=0 asserted in SHIFT of pattern 2 -> all outputs 0 asynchronously; a re-run after release matches the nominal run.
REQ-043 Bench SHALL cover bist_start held high through DONE, then dropped -> bist_end stays 1 until the drop, the FSM enters IDLE, and pass_nfail is retained.
